pipe_latch_hs: RTL and testbench
================================

// Module: pipe_latch_hs
// PURPOSE
//  Parametrised pipeline latch with valid/ready handshake, optional skid buffer, flush and stall counter.
//  Replaces the fixed enable-only latches between IF/ID/EX/MEM/WB; carries any packed stage struct
//  (ifetch_t, decode_t, exec_t, mem_t, regw_t) as an opaque WIDTH-bit vector. One instance per stage boundary.
// PARAMETERS
//  WIDTH    64   payload width; set to $bits(<stage struct>) at instantiation
//  SKID_EN  1    1: two-entry skid buffer, in_ready registered; 0: single entry, in_ready combinational
//  CNT_W    16   width of saturating stall counter
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       synchronous reset, active low
//  in_valid   in   1       upstream beat valid
//  in_data    in   WIDTH   upstream payload
//  in_ready   out  1       latch accepts beat this cycle
//  out_valid  out  1       downstream beat valid
//  out_data   out  WIDTH   downstream payload (head entry)
//  out_ready  in   1       downstream consumes head this cycle
//  flush      in   1       discard all held beats and any incoming beat (branch mispredict / jump)
//  stall_cnt  out  CNT_W   cycles with out_valid && !out_ready, saturating
//  cnt_clr    in   1       clear stall_cnt
// BEHAVIOUR
//  - Reset (nRST=0 at CLK edge): state=EMPTY, out_valid=0, out_data='0, skid data='0, stall_cnt=0.
//    in_ready=0 while nRST=0; no beat accepted during reset.
//  - Transfer in: in_valid && in_ready at edge. Transfer out: out_valid && out_ready at edge.
//  - Latency: accepted beat appears on out_valid/out_data the next cycle (1 cycle), order preserved.
//  - SKID_EN=1 states (latch_state_t): EMPTY, FULL (head only), SKID (head+skid).
//    in_ready = nRST && state!=SKID (from registers only, no out_ready path).
//    EMPTY: in -> FULL (head<=in_data).
//    FULL: in only -> SKID (skid<=in_data); out only -> EMPTY; in+out -> FULL (head<=in_data); neither -> hold.
//    SKID: out -> FULL (head<=skid); otherwise hold. No input possible.
//  - SKID_EN=0: state EMPTY/FULL only; in_ready = nRST && (!out_valid || out_ready).
//    in+out same cycle -> FULL with new data.
//  - out_valid = state!=EMPTY; out_data = head register; stale data held when EMPTY (not cleared).
//  - Flush: highest priority after reset. At edge with flush=1 -> state=EMPTY; incoming beat dropped
//    even if in_ready=1 (upstream sees handshake complete); data registers untouched.
//    flush and out_ready same cycle: head counts as consumed; no duplicate next cycle.
//  - stall_cnt: +1 per cycle with out_valid && !out_ready && !flush; saturates at 2^CNT_W-1, no wrap.
//    cnt_clr=1 -> 0 next cycle, priority over increment; reset also clears.
//  - Payload never modified; no width conversion; in_data X tolerated when in_valid=0.
//  - Any assertion: never out_valid transitions 1->0 without out_ready or flush.
// STRUCTURE
//  - Add to pipeline_if package: typedef enum logic [1:0] {EMPTY, FULL, SKID} latch_state_t.
//  - Stage structs stay in pipeline_if; callers cast via $bits()/struct assignment at instance.
//  - One sub-module: sat_counter #(CNT_W) (inc, clr, count) for stall_cnt; reusable for perf counters.
//  - generate on SKID_EN selects skid register + ready logic; head register and FSM shared.
// TESTING
//  1 Reset: nRST=0 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, stall_cnt=0; release -> in_ready=1.
//  2 Stream: in_valid=1 data 0x1..0x8, out_ready=1 -> out_data 0x1..0x8 one cycle later, no gaps, in_ready=1.
//  3 Backpressure (SKID_EN=1): send 0xA,0xB,0xC with out_ready=0 -> accepts 0xA,0xB, in_ready=0 at SKID,
//    0xC held upstream; out_ready=1 -> outputs 0xA,0xB,0xC in order; stall_cnt=cycles stalled.
//  4 Flush: state SKID holding 0xA,0xB, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, 0xC never out.
//  5 Saturation: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt stops at 15; cnt_clr=1 -> 0.
//  6 SKID_EN=0: out_ready=0 -> in_ready=0 same cycle; in+out same cycle -> new data next cycle, no bubble.

Source files
------------

// File: rtl/pipe_latch_hs_pkg.sv
// Shared types for the pipeline stage-boundary latch.
// Holds the latch state encoding and a handshake helper.
package pipe_latch_hs_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } latch_state_t;

  function automatic logic xfer(
    input logic valid,
    input logic ready
  );
    return valid && ready;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != {W{1'b1}}) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_latch_hs.sv
// Pipeline latch with valid/ready handshake, optional skid entry,
// flush and saturating stall counter.
module pipe_latch_hs
  import pipe_latch_hs_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             cnt_clr
);

  latch_state_t     state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = xfer(in_valid, in_ready);
  assign out_xfer  = xfer(out_valid, out_ready);
  assign out_valid = state != EMPTY;
  assign out_data  = head;

  generate
    if (SKID_EN != 0) begin : g_skid
      // Ready comes from state only, breaking the out_ready path.
      assign in_ready = nRST && state != SKID;

      always_ff @(posedge CLK) begin
        if (!nRST) begin
          skid <= '0;
        end else if (!flush && state == FULL
                     && in_xfer && !out_xfer) begin
          skid <= in_data;
        end
      end
    end else begin : g_noskid
      assign in_ready = nRST && (!out_valid || out_ready);
      assign skid     = '0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= EMPTY;
      head  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state <= FULL;
            head  <= in_data;
          end
        end
        FULL: begin
          unique case (1'b1)
            in_xfer && out_xfer: head <= in_data;
            in_xfer && !out_xfer: begin
              if (SKID_EN != 0) state <= SKID;
              else head <= in_data;
            end
            !in_xfer && out_xfer: state <= EMPTY;
            default: ;
          endcase
        end
        SKID: begin
          if (out_xfer) begin
            state <= FULL;
            head  <= skid;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (out_valid && !out_ready && !flush),
    .clr  (cnt_clr),
    .count(stall_cnt)
  );

  // A held beat may only leave through consumption or flush.
  a_hold : assert property (
    @(posedge CLK)
    (nRST && out_valid && !out_ready && !flush)
    |=> (out_valid || !nRST)
  );

endmodule

// File: tb/tb_pipe_latch_hs.sv
// Scoreboard bench for pipe_latch_hs: skid instance (CNT_W=4)
// and single-entry instance side by side.
module tb_pipe_latch_hs;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         nRST;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic         a_flush, a_clr;
  logic [W-1:0] a_in_data, a_out_data;
  logic [3:0]   a_stall;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic         b_flush, b_clr;
  logic [W-1:0] b_in_data, b_out_data;
  logic [15:0]  b_stall;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  always #5 CLK = ~CLK;

  pipe_latch_hs #(
    .WIDTH(W), .SKID_EN(1), .CNT_W(4)
  ) u_a (
    .CLK(CLK), .nRST(nRST),
    .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(a_out_ready),
    .flush(a_flush), .stall_cnt(a_stall), .cnt_clr(a_clr)
  );

  pipe_latch_hs #(
    .WIDTH(W), .SKID_EN(0), .CNT_W(16)
  ) u_b (
    .CLK(CLK), .nRST(nRST),
    .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(b_out_ready),
    .flush(b_flush), .stall_cnt(b_stall), .cnt_clr(b_clr)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitors: every output transfer must match the next expected beat.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_beat", {16'h0, a_out_data}, 32'hdead);
      end else begin
        chk("a_out_data", {16'h0, a_out_data},
            {16'h0, qa.pop_front()});
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST === 1'b1 && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_beat", {16'h0, b_out_data}, 32'hdead);
      end else begin
        chk("b_out_data", {16'h0, b_out_data},
            {16'h0, qb.pop_front()});
      end
    end
  end

  initial begin
    nRST = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h55;
    a_out_ready = 1'b1; a_flush = 1'b0; a_clr = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h55;
    b_out_ready = 1'b1; b_flush = 1'b0; b_clr = 1'b0;

    // reset with in_valid asserted
    step();
    step();
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_a_stall", a_stall, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    nRST = 1'b1;
    #1;
    chk("rel_a_in_ready", a_in_ready, 1);
    chk("rel_b_in_ready", b_in_ready, 1);
    step();
    chk("idle_a_out_valid", a_out_valid, 0);

    // streaming 1..8, no backpressure
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = W'(i); qa.push_back(W'(i));
      b_in_valid = 1'b1; b_in_data = W'(i); qb.push_back(W'(i));
      #1;
      chk("str_a_in_ready", a_in_ready, 1);
      chk("str_b_in_ready", b_in_ready, 1);
      step();
      chk("str_a_valid", a_out_valid, 1);
      chk("str_a_data", a_out_data, i);
      chk("str_b_data", b_out_data, i);
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    step();
    chk("str_a_drained", a_out_valid, 0);
    chk("str_b_drained", b_out_valid, 0);
    chk("str_a_stall", a_stall, 0);

    // backpressure into skid
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hA; qa.push_back(16'hA);
    step();
    chk("bp_a_valid", a_out_valid, 1);
    chk("bp_a_head", a_out_data, 16'hA);
    chk("bp_a_ready_full", a_in_ready, 1);
    chk("bp_a_stall0", a_stall, 0);
    a_in_data = 16'hB; qa.push_back(16'hB);
    step();
    chk("bp_a_ready_skid", a_in_ready, 0);
    chk("bp_a_stall1", a_stall, 1);
    chk("bp_a_head_hold", a_out_data, 16'hA);
    a_in_data = 16'hC;
    step();
    step();
    chk("bp_a_ready_held", a_in_ready, 0);
    chk("bp_a_stall3", a_stall, 3);
    a_out_ready = 1'b1;
    step();
    chk("bp_a_head_b", a_out_data, 16'hB);
    chk("bp_a_ready_again", a_in_ready, 1);
    qa.push_back(16'hC);
    step();
    chk("bp_a_head_c", a_out_data, 16'hC);
    a_in_valid = 1'b0;
    step();
    chk("bp_a_empty", a_out_valid, 0);
    chk("bp_a_stall_kept", a_stall, 3);

    // flush while holding two beats
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("clr_a_stall", a_stall, 0);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'hA;
    step();
    a_in_data = 16'hB;
    step();
    chk("fl_a_skid", a_in_ready, 0);
    a_flush = 1'b1;
    a_in_data = 16'hC;
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    chk("fl_a_valid", a_out_valid, 0);
    chk("fl_a_stall", a_stall, 1);
    chk("fl_a_ready", a_in_ready, 1);
    a_out_ready = 1'b1;
    step();
    step();
    chk("fl_a_still_empty", a_out_valid, 0);

    // flush accepting a beat while head is consumed
    a_in_valid = 1'b1; a_in_data = 16'h77; qa.push_back(16'h77);
    step();
    a_in_valid = 1'b1; a_in_data = 16'h88;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    chk("flo_a_valid", a_out_valid, 0);
    step();
    chk("flo_a_no_dup", a_out_valid, 0);

    // counter saturation on the 4-bit instance
    a_out_ready = 1'b0;
    a_clr = 1'b1;
    a_in_valid = 1'b1; a_in_data = 16'h5A; qa.push_back(16'h5A);
    step();
    a_clr = 1'b0;
    a_in_valid = 1'b0;
    chk("sat_a_start", a_stall, 0);
    repeat (10) step();
    chk("sat_a_10", a_stall, 10);
    repeat (10) step();
    chk("sat_a_15", a_stall, 15);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("sat_a_clr", a_stall, 0);
    step();
    chk("sat_a_restart", a_stall, 1);
    a_out_ready = 1'b1;
    step();
    chk("sat_a_drain", a_out_valid, 0);

    // single-entry ready path and back-to-back refill
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h11; qb.push_back(16'h11);
    step();
    b_in_valid = 1'b0;
    chk("ns_b_ready_low", b_in_ready, 0);
    step();
    chk("ns_b_stall", b_stall, 1);
    chk("ns_b_head", b_out_data, 16'h11);
    b_out_ready = 1'b1;
    #1;
    chk("ns_b_ready_comb", b_in_ready, 1);
    b_in_valid = 1'b1; b_in_data = 16'h22; qb.push_back(16'h22);
    step();
    chk("ns_b_refill_valid", b_out_valid, 1);
    chk("ns_b_refill_data", b_out_data, 16'h22);
    b_in_valid = 1'b0;
    step();
    chk("ns_b_empty", b_out_valid, 0);

    step();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
